// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: detects per-channel rising/falling edges, queues one
// event per channel and presents them round-robin on a valid/ready output.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   reset        synchronous active-low reset
//   a_i          monitored levels, one bit per channel
//   mode_i       per-channel edge select [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   evt_ready_i  consumer accepts the presented event
//   clr_ovf_i    clear all sticky overflow flags
//   evt_valid_o  an event is presented
//   evt_id_o     channel index of the presented event
//   evt_rise_o   presented event type: 1 rising, 0 falling
//   ovf_o        sticky per-channel overflow flags
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     a_i,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic                  evt_ready_i,
    input  logic                  clr_ovf_i,
    output logic                  evt_valid_o,
    output logic [ID_W-1:0]       evt_id_o,
    output logic                  evt_rise_o,
    output logic [NUM_CH-1:0]     ovf_o
);

    localparam logic [ID_W-1:0] LAST_CH = ID_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] d_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] type_q, type_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] edge_rise;
    logic [NUM_CH-1:0] qual;
    logic              valid_q;
    logic              rise_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   cand;
    logic              gnt_any;
    logic              gnt_v;
    logic              free;

    always_comb begin
        edge_rise = '0;
        qual      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            edge_rise[i] = a_i[i] & ~d_q[i];
            qual[i] = (edge_rise[i] & mode_i[2*i])
                    | (~a_i[i] & d_q[i] & mode_i[2*i+1]);
        end
    end

    assign free = ~valid_q | evt_ready_i;

    // Walk upward from last_grant+1 with wrap; first pending channel wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = last_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
            if (!gnt_any && pend_q[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    assign gnt_v = free & gnt_any;

    // The granted slot is freed first so a same-cycle edge lands in it
    // instead of counting as an overflow.
    always_comb begin
        pend_d = pend_q;
        type_d = type_q;
        ovf_d  = clr_ovf_i ? '0 : ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_v && gnt_id == ID_W'(i)) begin
                pend_d[i] = 1'b0;
            end
            if (qual[i]) begin
                if (pend_d[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    type_d[i] = edge_rise[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_q     <= '0;
            pend_q  <= '0;
            type_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            rise_q  <= 1'b0;
            last_q  <= LAST_CH;
        end else begin
            d_q    <= a_i;
            pend_q <= pend_d;
            type_q <= type_d;
            ovf_q  <= ovf_d;
            if (free) begin
                if (gnt_any) begin
                    valid_q <= 1'b1;
                    id_q    <= gnt_id;
                    rise_q  <= type_q[gnt_id];
                    last_q  <= gnt_id;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign evt_rise_o  = rise_q;
    assign ovf_o       = ovf_q;

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of monitored input channels (2..8).
REQ-002 Parameter ID_W, default 2, width of the channel index, equal to clog2(NUM_CH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; 0 sampled at a clk rising edge resets the block.
REQ-005 a_i  input  NUM_CH  monitored levels, one bit per channel, already synchronous to clk.
REQ-006 mode_i  input  2*NUM_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 evt_ready_i  input  1  consumer accepts the presented event.
REQ-008 clr_ovf_i  input  1  clears all overflow flags when high.
REQ-009 evt_valid_o  output  1  an event is presented.
REQ-010 evt_id_o  output  ID_W  channel index of the presented event.
REQ-011 evt_rise_o  output  1  presented event type: 1 rising, 0 falling.
REQ-012 ovf_o  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-013 Each channel SHALL hold a 1-bit previous-sample register d_q[i], loaded with a_i[i] every cycle.
REQ-014 Rising edge on channel i SHALL be a_i[i] & ~d_q[i]; falling edge SHALL be ~a_i[i] & d_q[i].
REQ-015 A detected edge SHALL be qualified by mode_i[i]; edges of an unselected type, and all edges when mode is 00, SHALL be ignored.
REQ-016 Each channel SHALL hold one pending slot: a pend[i] flag plus an edge-type bit.
REQ-017 A qualified edge with pend[i]=0 SHALL set pend[i] and record its type at the same clock edge.
REQ-018 A qualified edge with pend[i]=1, where channel i is not granted that cycle, SHALL be dropped, SHALL leave the stored type unchanged, and SHALL set ovf_o[i].
REQ-019 A qualified edge arriving in the same cycle that channel i is granted SHALL be captured into the freed slot, with no overflow.
REQ-020 The output register SHALL be "free" when evt_valid_o=0 or when evt_valid_o & evt_ready_i.
REQ-021 When the output register is free and any pend bit is set, the block SHALL grant one channel by round-robin: the first pending channel searching upward, with wrap, from last_grant+1.
REQ-022 A grant SHALL load evt_id_o and evt_rise_o, set evt_valid_o, clear the granted pend bit, and update last_grant, all at one clock edge.
REQ-023 When the output register is free and no pend bit is set, evt_valid_o SHALL go to 0 at the next clock edge.
REQ-024 While evt_valid_o=1 and evt_ready_i=0, evt_valid_o, evt_id_o and evt_rise_o SHALL hold stable.
REQ-025 Latency SHALL be 2 cycles: an edge present at clock edge N sets pend at N; the event is presented after edge N+1 if the output is free. Event throughput SHALL be 1 per cycle.
REQ-026 Changing mode_i SHALL NOT clear pending events; it affects only edges detected afterwards.
REQ-027 clr_ovf_i=1 SHALL clear ovf_o at the next clock edge; a new overflow in the same cycle SHALL take priority and set its bit.

Reset
REQ-028 Reset SHALL force the following: d_q all 0; pend all 0; evt_valid_o=0; evt_id_o=0; evt_rise_o=0; ovf_o all 0; last_grant=NUM_CH-1, so channel 0 has first priority.
REQ-029 Reset asserted mid-handshake SHALL discard the presented event and all pending events, with no event emitted after reset release.
REQ-030 A channel held high through reset release SHALL report a rising edge on the first cycle after release, when enabled.

Verification
REQ-031 Single edge: mode=01 on ch2, a_i[2] goes 0->1 with ready=1 -> after 2 edges evt_valid_o=1, evt_id_o=2, evt_rise_o=1 for exactly 1 cycle.
REQ-032 Fairness: ch0..ch3 all rise in the same cycle, mode=11, ready=1 -> events in order id 0,1,2,3 on consecutive cycles; a repeat burst is also ordered 0,1,2,3.
REQ-033 Backpressure: ready=0 with event ch1 presented, ch1 toggles twice -> outputs stay stable, ovf_o[1]=1, and the first queued type is retained; ready=1 then drains exactly one ch1 event.
REQ-034 Simultaneous grant and edge: ch3 granted in the same cycle it produces a new falling edge (mode=11) -> ovf_o[3]=0 and a second ch3 event with evt_rise_o=0 follows.
REQ-035 Filtering: mode=10 on ch0, pulse a_i[0] 0->1->0 -> exactly one event, evt_rise_o=0; with mode=00, no event.
REQ-036 Reset: assert reset=0 while evt_valid_o=1 and pending events exist -> all outputs 0 next cycle; release with a_i=0 -> no events.
